// File: rtl/stark_fpu_wb_fifo_pkg.sv
// Shared Stark types used by the FPU writeback buffer: ROB masks, reservation
// station entries, exception causes and the queued writeback entry.
package Stark_pkg;

  localparam int ROB_ENTRIES = 16;
  localparam int FPU_WID     = 64;

  typedef logic [ROB_ENTRIES-1:0]         rob_bitmask_t;
  typedef logic [$clog2(ROB_ENTRIES)-1:0] rob_ndx_t;

  typedef struct packed {
    logic     v;
    rob_ndx_t rndx;
    logic [3:0] rs_id;
  } reservation_station_entry_t;

  typedef enum logic [7:0] {
    FLT_NONE      = 8'h00,
    FLT_INVALID   = 8'h01,
    FLT_DIVZERO   = 8'h02,
    FLT_OVERFLOW  = 8'h03,
    FLT_UNDERFLOW = 8'h04,
    FLT_INEXACT   = 8'h05
  } cause_code_t;

  typedef struct packed {
    reservation_station_entry_t rse;
    logic [FPU_WID-1:0]         res;
    logic                       tag;
    logic [FPU_WID/8:0]         we;
    cause_code_t                exc;
    logic                       live;
  } fpu_wb_entry_t;

endpackage

// File: rtl/stark_fpu_wb_fifo_ram.sv
// DEPTH x fpu_wb_entry_t storage: one synchronous write port, one async read port.
// Contents are not reset; validity is tracked by the live flops in the parent.
module stark_fpu_wb_ram
  import Stark_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  fpu_wb_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fpu_wb_entry_t rdata_o
);

  fpu_wb_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stark_fpu_wb_fifo.sv
// FPU result writeback FIFO with in-place stomp squashing and credit stall.
// Optional same-cycle empty-path bypass: define STARK_FPU_WB_BYPASS_EN. WID must equal Stark_pkg::FPU_WID.
module stark_fpu_wb_fifo
  import Stark_pkg::*;
#(
  parameter int WID      = 64,
  parameter int DEPTH    = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic                       rst,
  input  logic                       clk,
  input  rob_bitmask_t               stomp,
  input  reservation_station_entry_t rse_i,
  input  logic [WID-1:0]             res_i,
  input  logic                       tag_i,
  input  logic [WID/8:0]             we_i,
  input  cause_code_t                exc_i,
  input  logic                       wr_ack,
  output logic                       wr_valid,
  output reservation_station_entry_t wr_rse,
  output logic [WID-1:0]             wr_res,
  output logic                       wr_tag,
  output logic [WID/8:0]             wr_we,
  output cause_code_t                wr_exc,
  output logic                       stall_o,
  output logic                       ovf_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [DEPTH-1:0] live_q, live_d;
  logic             ovf_q, ovf_d;
  rob_ndx_t         rndx_q [DEPTH];

  logic          empty, full, push_cond, push_en, pop, head_live;
  fpu_wb_entry_t wdata, head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign push_cond = rse_i.v && |we_i && !stomp[rse_i.rndx];
  assign head_live = !empty && live_q[rd_ptr_q] && head.live;
  assign pop       = head_live ? wr_ack : !empty;

  always_comb begin
    wdata      = '0;
    wdata.rse  = rse_i;
    wdata.res  = res_i;
    wdata.tag  = tag_i;
    wdata.we   = we_i;
    wdata.exc  = exc_i;
    wdata.live = 1'b1;
  end

`ifdef STARK_FPU_WB_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = empty && push_cond;
  // An acked bypass consumes the result outright, so it never enters storage.
  assign push_en    = push_cond && !(bypass_hit && wr_ack) && (!full || pop);
  assign wr_valid   = bypass_hit || head_live;
  assign wr_rse     = bypass_hit ? wdata.rse : head.rse;
  assign wr_res     = bypass_hit ? wdata.res : head.res;
  assign wr_tag     = bypass_hit ? wdata.tag : head.tag;
  assign wr_we      = bypass_hit ? wdata.we  : head.we;
  assign wr_exc     = bypass_hit ? wdata.exc : head.exc;
`else
  assign push_en    = push_cond && (!full || pop);
  assign wr_valid   = head_live;
  assign wr_rse     = head.rse;
  assign wr_res     = head.res;
  assign wr_tag     = head.tag;
  assign wr_we      = head.we;
  assign wr_exc     = head.exc;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push_en) - (AW+1)'(pop);
    ovf_d    = ovf_q || (push_cond && full && !pop);
    for (int i = 0; i < DEPTH; i++) begin
      live_d[i] = live_q[i] && !stomp[rndx_q[i]];
    end
    // Push after pop: on a full push+pop both pointers address the same slot.
    if (pop)     live_d[rd_ptr_q] = 1'b0;
    if (push_en) live_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) rndx_q[wr_ptr_q] <= rse_i.rndx;
  end

  assign stall_o = (count_q >= (AW+1)'(DEPTH - PIPE_LAT));
  assign ovf_o   = ovf_q;

  stark_fpu_wb_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (push_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

endmodule

// File: tb/tb_stark_fpu_wb_fifo.sv
// Directed, table-driven bench for stark_fpu_wb_fifo (default and bypass builds).
module tb_stark_fpu_wb_fifo;
  import Stark_pkg::*;

  logic                       rst, clk;
  rob_bitmask_t               stomp;
  reservation_station_entry_t rse_i, wr_rse;
  logic [63:0]                res_i, wr_res;
  logic                       tag_i, wr_tag, wr_ack, wr_valid, stall_o, ovf_o;
  logic [8:0]                 we_i, wr_we;
  cause_code_t                exc_i, wr_exc;

  int checks = 0;
  int failures = 0;

  stark_fpu_wb_fifo #(.WID(64), .DEPTH(4), .PIPE_LAT(2)) dut (
    .rst(rst), .clk(clk), .stomp(stomp), .rse_i(rse_i), .res_i(res_i),
    .tag_i(tag_i), .we_i(we_i), .exc_i(exc_i), .wr_ack(wr_ack),
    .wr_valid(wr_valid), .wr_rse(wr_rse), .wr_res(wr_res), .wr_tag(wr_tag),
    .wr_we(wr_we), .wr_exc(wr_exc), .stall_o(stall_o), .ovf_o(ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  rndx;
    logic [8:0]  we;
    logic [63:0] res;
    logic [15:0] stm;
    logic        ack;
    logic        exp_valid;
    logic [63:0] exp_res;
    logic        exp_stall;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [3:0] rndx, logic [8:0] we, logic [63:0] res,
                              logic [15:0] stm, logic ack, logic ev, logic [63:0] er,
                              logic es, logic eo);
    vec_t r;
    r.v = v; r.rndx = rndx; r.we = we; r.res = res; r.stm = stm; r.ack = ack;
    r.exp_valid = ev; r.exp_res = er; r.exp_stall = es; r.exp_ovf = eo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] rndx, input logic [8:0] we,
                       input logic [63:0] res, input logic [15:0] stm, input logic ack);
    rse_i  = '{v: v, rndx: rndx, rs_id: 4'd0};
    we_i   = we;
    res_i  = res;
    stomp  = stm;
    wr_ack = ack;
  endtask

  // Drive at negedge, let the clock rise, sample 1 time unit later.
  task automatic cyc(input logic v, input logic [3:0] rndx, input logic [8:0] we,
                     input logic [63:0] res, input logic [15:0] stm, input logic ack);
    @(negedge clk);
    drive(v, rndx, we, res, stm, ack);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic ev, input logic [63:0] er,
                           input logic es, input logic eo);
    chk({name, "_valid"}, 64'(wr_valid), 64'(ev));
    if (ev) chk({name, "_res"}, wr_res, er);
    chk({name, "_stall"}, 64'(stall_o), 64'(es));
    chk({name, "_ovf"}, 64'(ovf_o), 64'(eo));
  endtask

  localparam logic [63:0] R1 = 64'h3FF0_0000_0000_0000;

  initial begin
    rst = 1'b1;
    tag_i = 1'b0;
    exc_i = FLT_NONE;
    drive(1'b0, 4'd0, 9'h0, 64'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset", 1'b0, 64'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_state("post_reset", 1'b0, 64'h0, 1'b0, 1'b0);

`ifndef STARK_FPU_WB_BYPASS_EN
    // single result
    tbl.push_back(mk(1, 1, 9'h1FF, R1,     16'h0,    1, 1, R1,     0, 0));
    tbl.push_back(mk(0, 0, 9'h000, 64'h0,  16'h0,    1, 0, 64'h0,  0, 0));
    // stomp on arrival, zero we, invalid rse: nothing queued
    tbl.push_back(mk(1, 6, 9'h1FF, 64'h66, 16'h0040, 0, 0, 64'h0,  0, 0));
    tbl.push_back(mk(1, 2, 9'h000, 64'h22, 16'h0,    0, 0, 64'h0,  0, 0));
    tbl.push_back(mk(0, 2, 9'h1FF, 64'h22, 16'h0,    0, 0, 64'h0,  0, 0));
    tbl.push_back(mk(1, 2, 9'h003, 64'h20, 16'h0,    0, 1, 64'h20, 0, 0));
    tbl.push_back(mk(0, 0, 9'h000, 64'h0,  16'h0,    1, 0, 64'h0,  0, 0));
    // stomp in queue: rndx 5 dies and drains without ack
    tbl.push_back(mk(1, 3, 9'h1FF, 64'h33, 16'h0,    0, 1, 64'h33, 0, 0));
    tbl.push_back(mk(1, 5, 9'h1FF, 64'h55, 16'h0,    0, 1, 64'h33, 1, 0));
    tbl.push_back(mk(1, 7, 9'h1FF, 64'h77, 16'h0,    0, 1, 64'h33, 1, 0));
    tbl.push_back(mk(0, 0, 9'h000, 64'h0,  16'h0020, 0, 1, 64'h33, 1, 0));
    tbl.push_back(mk(0, 0, 9'h000, 64'h0,  16'h0,    1, 0, 64'h0,  1, 0));
    tbl.push_back(mk(0, 0, 9'h000, 64'h0,  16'h0,    0, 1, 64'h77, 0, 0));
    tbl.push_back(mk(0, 0, 9'h000, 64'h0,  16'h0,    1, 0, 64'h0,  0, 0));
    // fill, overflow, drain in order
    tbl.push_back(mk(1, 1, 9'h1FF, 64'h101, 16'h0,   0, 1, 64'h101, 0, 0));
    tbl.push_back(mk(1, 2, 9'h1FF, 64'h102, 16'h0,   0, 1, 64'h101, 1, 0));
    tbl.push_back(mk(1, 3, 9'h1FF, 64'h103, 16'h0,   0, 1, 64'h101, 1, 0));
    tbl.push_back(mk(1, 4, 9'h1FF, 64'h104, 16'h0,   0, 1, 64'h101, 1, 0));
    tbl.push_back(mk(1, 5, 9'h1FF, 64'h105, 16'h0,   0, 1, 64'h101, 1, 1));
    tbl.push_back(mk(0, 0, 9'h000, 64'h0,   16'h0,   1, 1, 64'h102, 1, 1));
    tbl.push_back(mk(0, 0, 9'h000, 64'h0,   16'h0,   1, 1, 64'h103, 1, 1));
    tbl.push_back(mk(0, 0, 9'h000, 64'h0,   16'h0,   1, 1, 64'h104, 0, 1));
    tbl.push_back(mk(0, 0, 9'h000, 64'h0,   16'h0,   1, 0, 64'h0,   0, 1));
    tbl.push_back(mk(0, 0, 9'h000, 64'h0,   16'h0,   0, 0, 64'h0,   0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].v, tbl[i].rndx, tbl[i].we, tbl[i].res, tbl[i].stm, tbl[i].ack);
      chk_state($sformatf("row%0d", i), tbl[i].exp_valid, tbl[i].exp_res,
                tbl[i].exp_stall, tbl[i].exp_ovf);
    end
`else
    // bypass: empty path presented in the same cycle, consumed when acked
    @(negedge clk);
    drive(1'b1, 4'd1, 9'h1FF, R1, 16'h0, 1'b1);
    #1;
    chk_state("byp_same", 1'b1, R1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_state("byp_consumed", 1'b0, 64'h0, 1'b0, 1'b0);
    // overflow so that the reset below has a sticky bit to clear
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'(i + 1), 9'h1FF, 64'(i + 'h101), 16'h0, 1'b0);
    chk_state("byp_ovf", 1'b1, 64'h101, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 9'h0, 64'h0, 16'h0, 1'b1);
`endif

    // reset mid-operation with 3 entries queued
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 8), 9'h1FF, 64'(i + 'hC0), 16'h0, 1'b0);
    chk_state("pre_rst", 1'b1, 64'hC0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'd0, 9'h0, 64'h0, 16'h0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 1'b0, 64'h0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 4'd9, 9'h1FF, 64'hAB, 16'h0, 1'b0);
    #1;
`ifdef STARK_FPU_WB_BYPASS_EN
    chk_state("rst_push_n", 1'b1, 64'hAB, 1'b0, 1'b0);
`else
    chk_state("rst_push_n", 1'b0, 64'h0, 1'b0, 1'b0);
`endif
    @(posedge clk);
    #1;
    chk_state("rst_push_n1", 1'b1, 64'hAB, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 9'h0, 64'h0, 16'h0, 1'b1);
    chk_state("rst_drained", 1'b0, 64'h0, 1'b0, 1'b0);

    // full FIFO with simultaneous push and pop: no overflow, count stays 4
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i + 1), 9'h1FF, 64'(i + 'hA1), 16'h0, 1'b0);
    chk_state("full", 1'b1, 64'hA1, 1'b1, 1'b0);
    cyc(1'b1, 4'd5, 9'h1FF, 64'hA5, 16'h0, 1'b1);
    chk_state("full_pushpop", 1'b1, 64'hA2, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 9'h0, 64'h0, 16'h0, 1'b1);
    chk_state("fp_pop1", 1'b1, 64'hA3, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 9'h0, 64'h0, 16'h0, 1'b1);
    chk_state("fp_pop2", 1'b1, 64'hA4, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 9'h0, 64'h0, 16'h0, 1'b1);
    chk_state("fp_pop3", 1'b1, 64'hA5, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 9'h0, 64'h0, 16'h0, 1'b1);
    chk_state("fp_empty", 1'b0, 64'h0, 1'b0, 1'b0);

    // head stomped this cycle still presents; drains next edge
    cyc(1'b1, 4'd4, 9'h1FF, 64'hD4, 16'h0, 1'b0);
    cyc(1'b1, 4'd6, 9'h1FF, 64'hD6, 16'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'd0, 9'h0, 64'h0, 16'h0010, 1'b0);
    #1;
    chk_state("stomp_head_same", 1'b1, 64'hD4, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_state("stomp_head_dead", 1'b0, 64'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 9'h0, 64'h0, 16'h0, 1'b0);
    chk_state("stomp_head_next", 1'b1, 64'hD6, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
